// File: rtl/lift_car_driver.sv
// rtl/lift_car_driver.sv - car-side motion/door command responder
// Executes one UP/DOWN/OPEN command at a time and owns the one-hot car position.
module lift_car_driver #(
   parameter int FLOOR_TICKS     = 4,
   parameter int DOOR_MOVE_TICKS = 2,
   parameter int DOOR_TICKS      = 3
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [1:0] cmd,
   output logic       cmd_ready,
   input  logic       door_hold,
   output logic [3:0] pos,
   output logic       moving,
   output logic       door_open,
   output logic       door_busy,
   output logic       done,
   output logic       err
);

   localparam int MAX_T0 = (FLOOR_TICKS > DOOR_MOVE_TICKS) ? FLOOR_TICKS : DOOR_MOVE_TICKS;
   localparam int MAX_T  = (MAX_T0 > DOOR_TICKS) ? MAX_T0 : DOOR_TICKS;
   localparam int TW     = $clog2(MAX_T) + 1;

   localparam logic [TW-1:0] FLOOR_RLD = TW'(FLOOR_TICKS - 1);
   localparam logic [TW-1:0] DMOVE_RLD = TW'(DOOR_MOVE_TICKS - 1);
   localparam logic [TW-1:0] DWELL_RLD = TW'(DOOR_TICKS - 1);

   localparam logic [1:0] CMD_UP   = 2'b01;
   localparam logic [1:0] CMD_DOWN = 2'b10;
   localparam logic [1:0] CMD_OPEN = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MOVE,
      S_OPENING,
      S_OPEN,
      S_CLOSING
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [3:0]    pos_q, pos_d;
   logic          dir_up_q, dir_up_d;
   logic          done_q, done_d;
   logic          rej_q, rej_d;
   logic          err_q, err_d;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         tmr_q    <= '0;
         pos_q    <= 4'b0001;
         dir_up_q <= 1'b0;
         done_q   <= 1'b0;
         rej_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         pos_q    <= pos_d;
         dir_up_q <= dir_up_d;
         done_q   <= done_d;
         rej_q    <= rej_d;
         err_q    <= err_d;
      end
   end

   // A rejected command is flagged on the accept edge and reported one edge later.
   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      pos_d    = pos_q;
      dir_up_d = dir_up_q;
      done_d   = 1'b0;
      rej_d    = 1'b0;
      err_d    = rej_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd)
                  CMD_UP: begin
                     if (pos_q[3]) begin
                        rej_d = 1'b1;
                     end else begin
                        state_d  = S_MOVE;
                        dir_up_d = 1'b1;
                        tmr_d    = FLOOR_RLD;
                     end
                  end
                  CMD_DOWN: begin
                     if (pos_q[0]) begin
                        rej_d = 1'b1;
                     end else begin
                        state_d  = S_MOVE;
                        dir_up_d = 1'b0;
                        tmr_d    = FLOOR_RLD;
                     end
                  end
                  CMD_OPEN: begin
                     state_d = S_OPENING;
                     tmr_d   = DMOVE_RLD;
                  end
                  default: rej_d = 1'b1;
               endcase
            end
         end
         S_MOVE: begin
            if (tmr_q == '0) begin
               pos_d   = dir_up_q ? (pos_q << 1) : (pos_q >> 1);
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_OPENING: begin
            if (tmr_q == '0) begin
               state_d = S_OPEN;
               tmr_d   = DWELL_RLD;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_OPEN: begin
            if (door_hold) begin
               tmr_d = DWELL_RLD;
            end else if (tmr_q == '0) begin
               state_d = S_CLOSING;
               tmr_d   = DMOVE_RLD;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_CLOSING: begin
            // An obstruction always wins, even on the edge the door would have shut.
            if (door_hold) begin
               state_d = S_OPENING;
               tmr_d   = DMOVE_RLD;
            end else if (tmr_q == '0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign moving    = (state_q == S_MOVE);
   assign door_open = (state_q == S_OPEN);
   assign door_busy = (state_q == S_OPENING) || (state_q == S_OPEN) || (state_q == S_CLOSING);
   assign pos       = pos_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
